// File: rtl/csi2_calib_pkg.sv
// Shared types and helpers for the CSI-2 lane-delay calibration controller.
package csi2_calib_pkg;

    localparam int CALIB_TAP_W = 5;
    localparam int TAPS        = 2**CALIB_TAP_W;

    typedef logic [CALIB_TAP_W-1:0] tap_t;
    typedef logic [CALIB_TAP_W:0]   eye_len_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SET_TAP,
        ST_SETTLE,
        ST_SYNC,
        ST_OBSERVE,
        ST_NEXT_TAP,
        ST_EVAL,
        ST_APPLY,
        ST_DONE
    } calib_state_t;

    // Centre of an eye, rounding towards the lower tap; len must be >= 1.
    function automatic tap_t eye_centre(input tap_t start, input eye_len_t len);
        eye_len_t half;
        half = (len - eye_len_t'(1)) >> 1;
        return start + tap_t'(half);
    endfunction

endpackage

// File: rtl/csi2_eye_finder.sv
// Serial scan of a tap pass bitmap: finds the longest run of ones, one bit
// per cycle. Bit 0 is consumed in the start cycle, so valid pulses exactly
// TAPS cycles after start. Ties keep the earliest (lowest) run.
module csi2_eye_finder
    import csi2_calib_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [TAPS-1:0] bitmap_i,
    output tap_t            best_start_o,
    output eye_len_t        best_len_o,
    output logic            valid_o
);

    logic [TAPS-1:0] shift_reg;
    tap_t            idx_reg;
    eye_len_t        run_len_reg;
    tap_t            run_start_reg;
    eye_len_t        best_len_reg;
    tap_t            best_start_reg;
    logic            active_reg;
    logic            valid_reg;

    logic     proc;
    logic     cur_bit;
    tap_t     cur_idx;
    eye_len_t prev_run;
    tap_t     prev_run_start;
    eye_len_t run_next;
    tap_t     run_start_next;
    eye_len_t best_len_next;
    tap_t     best_start_next;

    // Evaluate one bitmap position; a start request restarts from bit 0.
    always_comb begin
        proc            = start_i | active_reg;
        cur_bit         = start_i ? bitmap_i[0] : shift_reg[0];
        cur_idx         = start_i ? '0 : idx_reg;
        prev_run        = start_i ? '0 : run_len_reg;
        prev_run_start  = start_i ? '0 : run_start_reg;
        best_len_next   = start_i ? '0 : best_len_reg;
        best_start_next = start_i ? '0 : best_start_reg;
        run_next        = cur_bit ? prev_run + eye_len_t'(1) : '0;
        run_start_next  = (cur_bit && prev_run == '0) ? cur_idx : prev_run_start;
        if (cur_bit && run_next > best_len_next) begin
            best_len_next   = run_next;
            best_start_next = run_start_next;
        end
    end

    // Scan state: advance one bit per cycle while a scan is in progress.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shift_reg      <= '0;
            idx_reg        <= '0;
            run_len_reg    <= '0;
            run_start_reg  <= '0;
            best_len_reg   <= '0;
            best_start_reg <= '0;
            active_reg     <= 1'b0;
            valid_reg      <= 1'b0;
        end else if (proc) begin
            shift_reg      <= (start_i ? bitmap_i : shift_reg) >> 1;
            idx_reg        <= cur_idx + tap_t'(1);
            run_len_reg    <= run_next;
            run_start_reg  <= run_start_next;
            best_len_reg   <= best_len_next;
            best_start_reg <= best_start_next;
            active_reg     <= (cur_idx != tap_t'(TAPS-1));
            valid_reg      <= (cur_idx == tap_t'(TAPS-1));
        end else begin
            valid_reg      <= 1'b0;
        end
    end

    assign best_start_o = best_start_reg;
    assign best_len_o   = best_len_reg;
    assign valid_o      = valid_reg;

endmodule

// File: rtl/csi2_delay_calib.sv
// Lane-delay calibration: sweeps each lane's delay tap, judges every tap by
// link errors over whole frames, then centres each lane in its widest eye.
// TAP_W must match CALIB_TAP_W of the package (tap/eye typedefs).
module csi2_delay_calib
    import csi2_calib_pkg::*;
#(
    parameter int DATA_LANES     = 2,
    parameter int TAP_W          = CALIB_TAP_W,
    parameter int DEFAULT_TAP    = 16,
    parameter int SETTLE_CYCLES  = 64,
    parameter int FRAMES_PER_TAP = 2,
    parameter int MIN_EYE        = 3,
    parameter int TIMEOUT_CYCLES = 2**22
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              start_i,
    input  logic                              frame_start_i,
    input  logic                              header_err_i,
    input  logic                              crc_err_i,
    output logic [DATA_LANES*TAP_W-1:0]       lane_delay_o,
    output logic                              delay_act_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [DATA_LANES-1:0]             lane_fail_o,
    output logic [DATA_LANES*(TAP_W+1)-1:0]   eye_len_o
);

    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int FRM_W  = $clog2(FRAMES_PER_TAP + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LANE_W = (DATA_LANES > 1) ? $clog2(DATA_LANES) : 1;
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [FRM_W-1:0]  FRAME_LAST  = FRM_W'(FRAMES_PER_TAP - 1);
    localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(DATA_LANES - 1);

    calib_state_t      state_reg, state_next;
    tap_t              tap_reg;
    logic [LANE_W-1:0] lane_reg;
    logic [SET_W-1:0]  settle_cnt_reg;
    logic [FRM_W-1:0]  frame_cnt_reg;
    logic [TO_W-1:0]   timeout_cnt_reg;
    logic              tap_fail_reg;
    logic [TAPS-1:0]   bitmap_reg, bitmap_cur;
    logic              delay_act_reg;

    logic     start_go, observing, timeout_hit, last_frame, eye_go, apply_edge;
    tap_t     eye_start, apply_tap;
    eye_len_t eye_len;
    logic     eye_valid, apply_pass;

    assign start_go    = (state_reg == ST_IDLE || state_reg == ST_DONE) && start_i;
    assign observing   = (state_reg == ST_SYNC || state_reg == ST_OBSERVE);
    assign timeout_hit = observing && !frame_start_i && (timeout_cnt_reg == TO_LAST);
    assign last_frame  = (state_reg == ST_OBSERVE) && frame_start_i && (frame_cnt_reg == FRAME_LAST);
    // Results are registered as EVAL hands over to APPLY, so the final strobe
    // is high during APPLY and never abuts the next lane's first tap strobe.
    assign apply_edge  = (state_reg == ST_EVAL) && eye_valid;
    assign apply_pass  = (eye_len >= eye_len_t'(MIN_EYE));
    assign apply_tap   = apply_pass ? eye_centre(eye_start, eye_len) : tap_t'(DEFAULT_TAP);

    // Bitmap including the verdict of the tap currently being closed.
    always_comb begin
        bitmap_cur          = bitmap_reg;
        bitmap_cur[tap_reg] = ~tap_fail_reg;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic; also launches the eye scan after the last tap.
    always_comb begin
        state_next = state_reg;
        eye_go     = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: if (start_i) state_next = ST_SET_TAP;
            ST_SET_TAP:       state_next = ST_SETTLE;
            ST_SETTLE:        if (settle_cnt_reg == SETTLE_LAST) state_next = ST_SYNC;
            ST_SYNC: begin
                if (frame_start_i)    state_next = ST_OBSERVE;
                else if (timeout_hit) state_next = ST_NEXT_TAP;
            end
            ST_OBSERVE:       if (last_frame || timeout_hit) state_next = ST_NEXT_TAP;
            ST_NEXT_TAP: begin
                if (tap_reg == tap_t'(TAPS-1)) begin
                    state_next = ST_EVAL;
                    eye_go     = 1'b1;
                end else begin
                    state_next = ST_SET_TAP;
                end
            end
            ST_EVAL:          if (eye_valid) state_next = ST_APPLY;
            ST_APPLY:         state_next = (lane_reg == LANE_LAST) ? ST_DONE : ST_SET_TAP;
            default:          state_next = ST_IDLE;
        endcase
    end

    // Sweep counters, tap verdict and pass bitmap.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tap_reg         <= '0;
            lane_reg        <= '0;
            settle_cnt_reg  <= '0;
            frame_cnt_reg   <= '0;
            timeout_cnt_reg <= '0;
            tap_fail_reg    <= 1'b0;
            bitmap_reg      <= '0;
            delay_act_reg   <= 1'b0;
        end else begin
            delay_act_reg <= (state_reg == ST_SET_TAP) || apply_edge;
            if (start_go) begin
                tap_reg    <= '0;
                lane_reg   <= '0;
                bitmap_reg <= '0;
            end
            if (state_reg == ST_NEXT_TAP) begin
                bitmap_reg <= bitmap_cur;
                if (tap_reg != tap_t'(TAPS-1)) tap_reg <= tap_reg + tap_t'(1);
            end
            if (state_reg == ST_APPLY) begin
                tap_reg <= '0;
                if (lane_reg != LANE_LAST) lane_reg <= lane_reg + LANE_W'(1);
            end
            settle_cnt_reg <= (state_reg == ST_SETTLE) ? settle_cnt_reg + SET_W'(1) : '0;
            if (state_reg == ST_SYNC)
                frame_cnt_reg <= '0;
            else if (state_reg == ST_OBSERVE && frame_start_i)
                frame_cnt_reg <= frame_cnt_reg + FRM_W'(1);
            if (!observing || frame_start_i) timeout_cnt_reg <= '0;
            else                             timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
            // Errors only count once the link has settled on the new tap.
            if (state_reg == ST_SET_TAP)
                tap_fail_reg <= 1'b0;
            else if (observing && (header_err_i || crc_err_i || timeout_hit))
                tap_fail_reg <= 1'b1;
        end
    end

    csi2_eye_finder u_eye_finder (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_i      (eye_go),
        .bitmap_i     (bitmap_cur),
        .best_start_o (eye_start),
        .best_len_o   (eye_len),
        .valid_o      (eye_valid)
    );

    generate
        for (genvar gi = 0; gi < DATA_LANES; gi++) begin : g_lane
            tap_t     delay_reg;
            eye_len_t eye_len_reg;
            logic     fail_reg;
            logic     sel;

            assign sel = (lane_reg == LANE_W'(gi));

            // Per-lane tap, eye length and failure flag.
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    delay_reg   <= tap_t'(DEFAULT_TAP);
                    eye_len_reg <= '0;
                    fail_reg    <= 1'b0;
                end else begin
                    if (start_go) begin
                        eye_len_reg <= '0;
                        fail_reg    <= 1'b0;
                    end
                    if (state_reg == ST_SET_TAP && sel)
                        delay_reg <= tap_reg;
                    if (apply_edge && sel) begin
                        delay_reg   <= apply_tap;
                        eye_len_reg <= eye_len;
                        fail_reg    <= ~apply_pass;
                    end
                end
            end

            assign lane_delay_o[gi*TAP_W +: TAP_W]       = delay_reg;
            assign eye_len_o[gi*(TAP_W+1) +: (TAP_W+1)] = eye_len_reg;
            assign lane_fail_o[gi]                      = fail_reg;
        end
    endgenerate

    assign delay_act_o = delay_act_reg;
    assign busy_o      = !(state_reg == ST_IDLE || state_reg == ST_DONE);
    assign done_o      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_csi2_delay_calib.sv
// Directed bench for csi2_delay_calib: a link model turns the swept lane's
// tap into frame errors from a per-lane pass mask.
module tb_csi2_delay_calib;

    localparam int TW   = 5;
    localparam int NL   = 2;
    localparam int FP   = 16;   // frame period in cycles
    localparam int TMO  = 100;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic fs = 1'b0, herr = 1'b0, cerr = 1'b0;
    logic [NL*TW-1:0]     lane_delay;
    logic                 delay_act, busy, done;
    logic [NL-1:0]        lane_fail;
    logic [NL*(TW+1)-1:0] eye_len;

    csi2_delay_calib #(
        .DATA_LANES(NL), .TAP_W(TW), .DEFAULT_TAP(16), .SETTLE_CYCLES(4),
        .FRAMES_PER_TAP(2), .MIN_EYE(3), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .frame_start_i(fs),
        .header_err_i(herr), .crc_err_i(cerr), .lane_delay_o(lane_delay),
        .delay_act_o(delay_act), .busy_o(busy), .done_o(done),
        .lane_fail_o(lane_fail), .eye_len_o(eye_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] m0;
        logic [31:0] m1;
        int stop;
        bit noise;
        bit mid;
        int d0; int d1; int l0; int l1; int fail;
    } vec_t;

    vec_t vecs[6];
    logic [31:0] mask0 = '0, mask1 = '0;
    int  stop_tap = -1;
    bit  noise = 1'b0;
    int  pulse_cnt = 0, width_viol = 0, case_base = 0, fcnt = 0;
    bit  prev_act = 1'b0;
    int  n_cmp = 0, n_fail = 0;

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int dly(input int l);
        return int'(lane_delay[l*TW +: TW]);
    endfunction

    function automatic int elen(input int l);
        return int'(eye_len[l*(TW+1) +: (TW+1)]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Strobe monitor: counts delay_act pulses and flags any wider than 1 cycle.
    initial forever begin
        @(posedge clk);
        #1;
        if (delay_act === 1'b1) begin
            pulse_cnt++;
            if (prev_act) width_viol++;
        end
        prev_act = (delay_act === 1'b1);
    end

    // Link model: frames every FP cycles; errors when the swept tap is outside
    // the swept lane's pass mask. Pulses 1..33 of a run belong to lane 0.
    initial forever begin
        int  swept, tap;
        bit  on, bad;
        @(negedge clk);
        fcnt++;
        swept = ((pulse_cnt - case_base) <= 33) ? 0 : 1;
        tap   = dly(swept);
        on    = !(stop_tap >= 0 && swept == 0 && busy && tap == stop_tap);
        fs    = on && (fcnt % FP == 0);
        bad   = fs && !(swept == 0 ? mask0[tap] : mask1[tap]);
        herr  = (bad && (fcnt % (2*FP) == 0)) || (noise && delay_act);
        cerr  = bad && (fcnt % (2*FP) != 0);
    end

    task automatic run_cal(input bit mid, input string tag);
        int cyc;
        case_base = pulse_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, " busy_rise"}, int'(busy), 1);
        check({tag, " done_clear"}, int'(done), 0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 12000) begin
            @(negedge clk);
            cyc++;
            start = (mid && cyc == 500);
            if (mid && cyc == 502) check({tag, " busy_after_start"}, int'(busy), 1);
        end
        start = 1'b0;
        check({tag, " done"}, int'(done), 1);
    endtask

    task automatic check_result(input vec_t v, input string tag);
        check({tag, " lane0_delay"}, dly(0), v.d0);
        check({tag, " lane1_delay"}, dly(1), v.d1);
        check({tag, " lane0_eye"}, elen(0), v.l0);
        check({tag, " lane1_eye"}, elen(1), v.l1);
        check({tag, " lane_fail"}, int'(lane_fail), v.fail);
        check({tag, " busy_idle"}, int'(busy), 0);
        check({tag, " act_pulses"}, pulse_cnt - case_base, 66);
        check({tag, " act_width"}, width_viol, 0);
        $display("%s: delay={%0d,%0d} eye={%0d,%0d} fail=%0d", tag,
                 dly(1), dly(0), elen(1), elen(0), lane_fail);
    endtask

    task automatic load(input vec_t v);
        mask0 = v.m0; mask1 = v.m1; stop_tap = v.stop; noise = v.noise;
    endtask

    initial begin
        int cyc, pre;
        vecs[0] = '{rng(10, 20), rng(4, 8), -1, 1'b0, 1'b0, 15, 6, 11, 5, 0};
        vecs[1] = '{rng(2, 5) | rng(20, 23), rng(4, 8), -1, 1'b0, 1'b0, 3, 6, 4, 5, 0};
        vecs[2] = '{rng(10, 20), rng(7, 8), -1, 1'b0, 1'b0, 15, 16, 11, 2, 2};
        vecs[3] = '{rng(8, 16), rng(4, 8), 12, 1'b0, 1'b0, 9, 6, 4, 5, 0};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b1, 1'b1, 15, 15, 32, 32, 0};
        vecs[5] = '{32'h0, rng(29, 31), -1, 1'b0, 1'b0, 16, 30, 0, 3, 1};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst lane0_delay", dly(0), 16);
        check("rst lane1_delay", dly(1), 16);
        check("rst delay_act", int'(delay_act), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst lane_fail", int'(lane_fail), 0);
        check("rst eye_len", int'(eye_len), 0);
        $display("reset: delay={%0d,%0d} busy=%0d done=%0d", dly(1), dly(0), busy, done);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("case%0d", i);
            load(vecs[i]);
            run_cal(vecs[i].mid, tag);
            check_result(vecs[i], tag);
            repeat (3) @(negedge clk);
        end

        // Reset in the middle of an observation window, then a clean rerun.
        load(vecs[0]);
        case_base = pulse_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while ((pulse_cnt - case_base) < 10 && cyc < 3000) begin @(posedge clk); cyc++; end
        check("midrst reached_tap", int'((pulse_cnt - case_base) >= 10), 1);
        for (int k = 0; k < 2; k++) begin
            cyc = 0;
            do begin @(posedge clk); #1; cyc++; end while (fs !== 1'b1 && cyc < 200);
        end
        repeat (3) @(negedge clk);
        check("midrst busy_before", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst lane0_delay", dly(0), 16);
        check("midrst lane1_delay", dly(1), 16);
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst delay_act", int'(delay_act), 0);
        check("midrst eye_len", int'(eye_len), 0);
        pre = pulse_cnt;
        repeat (5) @(negedge clk);
        check("midrst no_act", pulse_cnt - pre, 0);
        $display("midrst: delay={%0d,%0d} busy=%0d", dly(1), dly(0), busy);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_cal(1'b0, "rerun");
        check_result(vecs[0], "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
